// File: rtl/gate_pkg.sv
// gate_pkg: opcode constants and sequencer state encoding shared by the gate arbiter blocks
package gate_pkg;
  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/glogic_unit.sv
// glogic_unit: shared combinational W-bit AND/OR/XOR/NAND evaluator
module glogic_unit
  import gate_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);
  // bitwise evaluation; OR path behaves as the gor primitive
  always_comb
    y = op == OP_AND ? (a & b) :
        op == OP_OR  ? (a | b) :
        op == OP_XOR ? (a ^ b) : ~(a & b);
endmodule

// File: rtl/gate_share_arbiter.sv
// gate_share_arbiter: round-robin sequencer sharing one glogic_unit among N requesters
module gate_share_arbiter
  import gate_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  input  logic [N*2-1:0]   op_in,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     ack,
  output logic [W-1:0]     y,
  output logic             busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic [N-1:0]  win_oh;
  logic [W-1:0]  a_s;
  logic [W-1:0]  b_s;
  logic [1:0]    op_s;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [1:0]    op_q;
  logic [W-1:0]  f;
  // round-robin pick: scan from last+1 downward in priority so the nearest requester wins
  always_comb begin
    win = last;
    idx = last;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N);
      if (req[idx]) win = idx;
    end
  end
  // steer the winner's operands and build its one-hot grant
  always_comb begin
    a_s    = '0;
    b_s    = '0;
    op_s   = OP_AND;
    win_oh = '0;
    for (int i = 0; i < N; i++)
      if (win == IW'(i)) begin
        a_s       = a_in[i*W +: W];
        b_s       = b_in[i*W +: W];
        op_s      = op_in[i*2 +: 2];
        win_oh[i] = 1'b1;
      end
  end
  glogic_unit #(.W(W)) u_logic (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (f)
  );
  // IDLE grants and latches, EXEC registers result and acks, DONE releases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      ack   <= '0;
      y     <= '0;
      busy  <= 1'b0;
      last  <= IW'(N - 1);
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_AND;
    end else begin
      case (state)
        ST_IDLE: if (|req) begin
          a_q   <= a_s;
          b_q   <= b_s;
          op_q  <= op_s;
          gnt   <= win_oh;
          last  <= win;
          busy  <= 1'b1;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          y     <= f;
          ack   <= gnt;
          state <= ST_DONE;
        end
        ST_DONE: begin
          ack   <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          gnt   <= '0;
          ack   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gate_share_arbiter.sv
// tb_gate_share_arbiter: randomized self-checking bench against a transaction-level model
module tb_gate_share_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] a_in  = '0;
  logic [N*W-1:0] b_in  = '0;
  logic [N*2-1:0] op_in = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   y;
  logic           busy;
  int checks = 0;
  int errors = 0;
  int last_m = N - 1;
  int cyc = 0;
  int t_ack = 0;
  logic [W-1:0] y_m = '0;

  gate_share_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .gnt(gnt), .ack(ack), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    checks++;
    if (!$onehot0(gnt) || !$onehot0(ack)) begin
      errors++;
      $display("FAIL onehot gnt=%b ack=%b", gnt, ack);
    end
  end

  function automatic int rr(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] gate_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    last_m = N - 1;
    y_m = '0;
  endtask

  task automatic do_txn(input string tag, output int w);
    logic [W-1:0] ey;
    logic [N-1:0] oh;
    w = rr(req, last_m);
    if (w < 0) begin
      errors++;
      checks++;
      $display("FAIL %s no_request req=%b", tag, req);
      return;
    end
    ey = gate_f(op_in[w*2 +: 2], a_in[w*W +: W], b_in[w*W +: W]);
    oh = '0;
    oh[w] = 1'b1;
    step;
    checks++;
    if (gnt !== oh || ack !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s grant gnt=%b ack=%b busy=%b want gnt=%b ack=0 busy=1", tag, gnt, ack, busy, oh);
    end
    step;
    t_ack = cyc;
    checks++;
    if (ack !== oh || gnt !== oh || y !== ey || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s ack ack=%b gnt=%b y=%b want ack=%b gnt=%b y=%b", tag, ack, gnt, y, oh, oh, ey);
    end
    step;
    checks++;
    if (ack !== '0 || gnt !== '0 || busy !== 1'b0 || y !== ey) begin
      errors++;
      $display("FAIL %s release ack=%b gnt=%b busy=%b y=%b want 0 0 0 y=%b", tag, ack, gnt, busy, y, ey);
    end
    last_m = w;
    y_m = ey;
  endtask

  task automatic test_reset;
    int w;
    req = 4'b1111;
    #1 rst = 1'b1;
    step;
    step;
    checks++;
    if (gnt !== '0 || ack !== '0 || y !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset gnt=%b ack=%b y=%b busy=%b want all 0", gnt, ack, y, busy);
    end
    rst = 1'b0;
    last_m = N - 1;
    do_txn("reset_first", w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL reset_winner got=%0d want=0", w);
    end
    req = '0;
  endtask

  task automatic test_single_or;
    int w;
    req = 4'b0100;
    a_in[2*W +: W] = 4'b0001;
    b_in[2*W +: W] = 4'b0000;
    op_in[2*2 +: 2] = 2'd1;
    do_txn("single_or", w);
    checks++;
    if (y !== 4'b0001) begin
      errors++;
      $display("FAIL single_or_y got=%b want=0001", y);
    end
    req = '0;
  endtask

  task automatic test_opcode_sweep;
    int w;
    logic [W-1:0] want [4];
    want[0] = 4'b1000;
    want[1] = 4'b1110;
    want[2] = 4'b0110;
    want[3] = 4'b0111;
    a_in[1*W +: W] = 4'b1100;
    b_in[1*W +: W] = 4'b1010;
    for (int o = 0; o < 4; o++) begin
      req = 4'b0010;
      op_in[1*2 +: 2] = 2'(o);
      do_txn("sweep", w);
      checks++;
      if (y !== want[o]) begin
        errors++;
        $display("FAIL sweep_op%0d got=%b want=%b", o, y, want[o]);
      end
    end
    req = '0;
  endtask

  task automatic test_fairness;
    int w;
    int t0;
    apply_reset;
    req = 4'b1111;
    for (int i = 0; i < N * W; i++) begin
      a_in[i] = 1'($urandom);
      b_in[i] = 1'($urandom);
    end
    op_in = 8'($urandom);
    t0 = 0;
    for (int i = 0; i < 5; i++) begin
      do_txn("fair", w);
      checks++;
      if (w != i % N) begin
        errors++;
        $display("FAIL fair_order idx=%0d got=%0d want=%0d", i, w, i % N);
      end
      if (i == 0) t0 = t_ack;
    end
    checks++;
    if (t_ack - t0 != 12) begin
      errors++;
      $display("FAIL fair_period got=%0d want=12", t_ack - t0);
    end
    req = '0;
  endtask

  task automatic test_operand_hold;
    logic [W-1:0] ey;
    req = 4'b0010;
    a_in[1*W +: W] = 4'b0101;
    b_in[1*W +: W] = 4'b0011;
    op_in[1*2 +: 2] = 2'd2;
    ey = 4'b0110;
    step;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL hold_grant got=%b want=0010", gnt);
    end
    a_in[1*W +: W] = 4'b1111;
    op_in[1*2 +: 2] = 2'd0;
    req = '0;
    step;
    checks++;
    if (ack !== 4'b0010 || y !== ey) begin
      errors++;
      $display("FAIL hold_ack ack=%b y=%b want ack=0010 y=%b", ack, y, ey);
    end
    step;
    checks++;
    if (ack !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release ack=%b busy=%b want 0 0", ack, busy);
    end
    last_m = 1;
    y_m = ey;
  endtask

  task automatic test_reset_mid;
    int w;
    logic seen;
    req = 4'b1000;
    a_in[3*W +: W] = 4'b1111;
    b_in[3*W +: W] = 4'b1111;
    op_in[3*2 +: 2] = 2'd0;
    step;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ack !== '0 || gnt !== '0 || y !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async ack=%b gnt=%b y=%b busy=%b want all 0", ack, gnt, y, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      if (ack !== '0) seen = 1'b1;
    end
    checks++;
    if (seen || y !== '0) begin
      errors++;
      $display("FAIL rst_mid_noack ack_seen=%b y=%b want 0 0000", seen, y);
    end
    rst = 1'b0;
    last_m = N - 1;
    do_txn("rst_mid_resume", w);
    checks++;
    if (w != 3 || y !== 4'b1111) begin
      errors++;
      $display("FAIL rst_mid_resume w=%0d y=%b want 3 1111", w, y);
    end
    req = '0;
  endtask

  task automatic test_random;
    int w;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        req = '0;
        a_in = 16'($urandom);
        repeat ($urandom_range(1, 3)) step;
        checks++;
        if (y !== y_m || busy !== 1'b0 || gnt !== '0 || ack !== '0) begin
          errors++;
          $display("FAIL rand_idle y=%b busy=%b gnt=%b ack=%b want y=%b idle", y, busy, gnt, ack, y_m);
        end
      end else begin
        req = 4'($urandom_range(1, 15));
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        op_in = 8'($urandom);
        do_txn("rand", w);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset;
    test_single_or;
    test_opcode_sweep;
    test_fairness;
    test_operand_hold;
    test_reset_mid;
    test_random;
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_share_arbiter.md
# gate_share_arbiter

Round-robin arbiter and sequencer that shares one combinational W-bit logic unit (AND/OR/XOR/NAND) among N requesters. Each requester presents operands, an opcode and a request; the arbiter grants one requester at a time, latches its operands, evaluates them and returns a registered result with a one-cycle acknowledge. It sits between the trab1 gate primitives and any client blocks that need gate evaluation without owning a private gate instance.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- W, 1, operand/result width in bits (bitwise operation)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req  in  N  request per requester; held high until that requester's ack
- a_in  in  N*W  operand A, requester i at bits [i*W +: W]
- b_in  in  N*W  operand B, same packing
- op_in  in  N*2  opcode, requester i at [i*2 +: 2]; 0 AND, 1 OR, 2 XOR, 3 NAND
- gnt  out  N  one-hot grant; high in EXEC and DONE
- ack  out  N  one-hot, one-cycle result-valid pulse to the granted requester
- y  out  W  result of the last completed transaction; holds value until next completion
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: if any req bit is high, select winner by round-robin, starting search at (last+1) mod N and wrapping; latch a_q, b_q, op_q from the winner; gnt <= one-hot(winner); last <= winner; go to EXEC. If req == 0, stay in IDLE; all outputs hold.
- EXEC: y <= f(op_q, a_q, b_q); ack <= gnt; go to DONE.
- DONE: ack <= 0; gnt <= 0; go to IDLE.
- Operands are sampled only on the IDLE->EXEC edge; changes to a_in/b_in/op_in/req after that edge do not affect the transaction in progress. A req dropped during EXEC or DONE does not cancel it: ack is still issued.
- A requester whose req is still high in the first IDLE cycle after its ack is treated as a new request. Round-robin still favours other pending requesters.
- Arithmetic: pure bitwise; NAND = ~(a & b) over W bits. No carries and no width growth.
- Reset values: state IDLE, gnt 0, ack 0, y 0, busy 0, last N-1, so requester 0 has top priority after reset. Operand registers are cleared to 0.
- Reset mid-transaction: the transaction is abandoned immediately (asynchronously) with no ack. The requester keeps req high and is re-arbitrated after reset release.

## Timing
- Latency: req sampled high at edge E0 (IDLE) -> ack high and y valid after edge E1 -> ack low after E2. The earliest next grant is at edge E3.
- Throughput: one transaction per 3 cycles under continuous load.
- With all N requesting continuously, grants rotate 0,1,..,N-1,0,... Worst-case wait is (N-1)*3 cycles before a grant.
- gnt, ack, y and busy are all registered; there is no combinational path from inputs to outputs.
- ack and gnt are never multi-hot. ack only pulses during DONE.

## Structure
- Shared package gate_pkg holds:
  - opcode constants OP_AND=2'd0, OP_OR=2'd1, OP_XOR=2'd2, OP_NAND=2'd3
  - state encoding ST_IDLE, ST_EXEC, ST_DONE (2 bits)
- Sub-module glogic_unit: combinational, parameter W, ports a, b, op, y. It is the shared resource and reuses the gor behaviour for OP_OR.
- The round-robin picker is a function or always block inside gate_share_arbiter, not a separate module.

## Test plan
- Reset: assert rst for 2 cycles with req=4'b1111 -> gnt=0, ack=0, y=0, busy=0. After release, the first grant goes to requester 0.
- Single OR (W=1): req=4'b0100, requester 2 a=1, b=0, op=1 -> gnt=4'b0100 for 2 cycles; ack=4'b0100 for exactly 1 cycle; y=1 two edges after the request is sampled.
- Opcode sweep (W=4) on requester 1 with a=4'b1100, b=4'b1010 -> y=1000 (AND), 1110 (OR), 0110 (XOR), 0111 (NAND).
- Fairness: req=4'b1111 held continuously -> acks in order 0,1,2,3,0. Each requester gets one ack per 12 cycles. No multi-hot gnt/ack at any time.
- Operand hold: change a_in, op_in and drop req of the granted requester during EXEC -> ack still issued; y reflects the values latched at grant.
- Reset mid-op: assert rst during EXEC -> ack never pulses, y=0. After release, the still-pending requester completes normally.
